// File: rtl/display_pkg.sv
// Shared 640x480p60 timing constants, FSM state type and sync-window helper
// for the display timing generator.
package display_pkg;

  localparam int   DEF_H_RES         = 640;
  localparam int   DEF_H_FP          = 16;
  localparam int   DEF_H_SYNC        = 96;
  localparam int   DEF_H_BP          = 48;
  localparam int   DEF_V_RES         = 480;
  localparam int   DEF_V_FP          = 10;
  localparam int   DEF_V_SYNC        = 2;
  localparam int   DEF_V_BP          = 33;
  localparam logic DEF_SYNC_POL      = 1'b0;
  localparam int   DEF_SETTLE_CYCLES = 16;
  localparam int   DEF_CORDW         = 10;

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} disp_state_t;

  // Unsigned half-open window test: lo <= pos < lo+len, written to avoid lo+len overflow.
  function automatic logic in_window(input logic [31:0] pos, input logic [31:0] lo,
                                     input logic [31:0] len);
    return (pos >= lo) && ((pos - lo) < len);
  endfunction

endpackage

// File: rtl/display_timing_640x480_if.sv
// Raster output bus: coordinates, syncs, data-enable, strobes and frame count.
interface display_timing_640x480_if
  import display_pkg::*;
#(
  parameter int CORDW = DEF_CORDW
);
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             line_start;
  logic             frame_start;
  logic [15:0]      frame_count;
  logic             running;

  modport master (output sx, sy, hsync, vsync, de, line_start, frame_start, frame_count, running);
  modport slave  (input  sx, sy, hsync, vsync, de, line_start, frame_start, frame_count, running);
endinterface

// File: rtl/display_timing_640x480.sv
// Lock-qualified raster timing generator: waits for a stable pixel-clock lock,
// then emits registered, mutually aligned coordinates, syncs and strobes.
module display_timing_640x480
  import display_pkg::*;
#(
  parameter int   H_RES         = DEF_H_RES,
  parameter int   H_FP          = DEF_H_FP,
  parameter int   H_SYNC        = DEF_H_SYNC,
  parameter int   H_BP          = DEF_H_BP,
  parameter int   V_RES         = DEF_V_RES,
  parameter int   V_FP          = DEF_V_FP,
  parameter int   V_SYNC        = DEF_V_SYNC,
  parameter int   V_BP          = DEF_V_BP,
  parameter logic SYNC_POL      = DEF_SYNC_POL,
  parameter int   SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int   CORDW         = DEF_CORDW
) (
  input  logic                       clk_25m,
  input  logic                       rst,
  input  logic                       clk_25m_locked,
  display_timing_640x480_if.master   vid
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (H_TOTAL > (1 << CORDW)) begin : g_htot_chk
    $error("H_TOTAL does not fit in CORDW bits");
  end
  if (V_TOTAL > (1 << CORDW)) begin : g_vtot_chk
    $error("V_TOTAL does not fit in CORDW bits");
  end
  if (SETTLE_CYCLES < 1) begin : g_settle_chk
    $error("SETTLE_CYCLES must be at least 1");
  end

  disp_state_t      state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic             running_q, running_d;
  logic             active;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      WAIT_LOCK: if (clk_25m_locked) begin
        state_d  = SETTLE;
        settle_d = '0;
      end
      SETTLE: begin
        if (!clk_25m_locked)                          state_d  = WAIT_LOCK;
        else if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d  = RUN;
        else                                          settle_d = settle_q + 1'b1;
      end
      RUN:     if (!clk_25m_locked) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  // The output stage trails the FSM by one register; lock loss in RUN idles
  // it on the very edge that samples the drop. The first active cycle after
  // entering RUN starts the raster at (0,0).
  always_comb begin
    active        = (state_q == RUN) && clk_25m_locked;
    sx_d          = '0;
    sy_d          = '0;
    frame_count_d = '0;
    if (active && running_q) begin
      frame_count_d = frame_count_q;
      sy_d          = sy_q;
      if (sx_q == CORDW'(H_TOTAL - 1)) begin
        if (sy_q == CORDW'(V_TOTAL - 1)) begin
          sy_d          = '0;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          sy_d = sy_q + 1'b1;
        end
      end else begin
        sx_d = sx_q + 1'b1;
      end
    end
    running_d     = active;
    de_d          = active && in_window(32'(sx_d), 0, H_RES) && in_window(32'(sy_d), 0, V_RES);
    hsync_d       = (active && in_window(32'(sx_d), H_RES + H_FP, H_SYNC)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (active && in_window(32'(sy_d), V_RES + V_FP, V_SYNC)) ? SYNC_POL : ~SYNC_POL;
    line_start_d  = active && (sx_d == '0);
    frame_start_d = active && (sx_d == '0) && (sy_d == '0);
  end

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q       <= WAIT_LOCK;
      settle_q      <= '0;
      sx_q          <= '0;
      sy_q          <= '0;
      frame_count_q <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign vid.sx          = sx_q;
  assign vid.sy          = sy_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.frame_count = frame_count_q;
  assign vid.running     = running_q;

endmodule

// File: tb/tb_display_timing_640x480.sv
// Directed bench: default 640x480 instance for line-level timing, plus a tiny
// raster instance (16x8, active-high syncs, 3-cycle settle) for frame-level behaviour.
module tb_display_timing_640x480;

  logic clk_25m = 1'b0;
  logic rst     = 1'b1;
  logic locked  = 1'b0;
  int   checks  = 0;
  int   passed  = 0;

  always #20 clk_25m = ~clk_25m;

  display_timing_640x480_if #(.CORDW(10)) vb ();
  display_timing_640x480_if #(.CORDW(5))  vs ();

  display_timing_640x480 dut_big (
    .clk_25m(clk_25m), .rst(rst), .clk_25m_locked(locked), .vid(vb)
  );

  display_timing_640x480 #(
    .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .SETTLE_CYCLES(3), .CORDW(5)
  ) dut_small (
    .clk_25m(clk_25m), .rst(rst), .clk_25m_locked(locked), .vid(vs)
  );

  task automatic step();
    @(posedge clk_25m);
    @(negedge clk_25m);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    locked = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if ({vb.sx, vb.sy, vb.hsync, vb.vsync, vb.de, vb.line_start, vb.frame_start, vb.frame_count, vb.running}
          !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0})
        $display("FAIL reset_idle_big cycle %0d: got sx=%0d sy=%0d hs=%b vs=%b de=%b run=%b expected idle",
                 i, vb.sx, vb.sy, vb.hsync, vb.vsync, vb.de, vb.running);
      else passed++;
    end
    checks++;
    if ({vs.sx, vs.sy, vs.hsync, vs.vsync, vs.de, vs.line_start, vs.frame_start, vs.frame_count, vs.running}
        !== {5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0})
      $display("FAIL reset_idle_small: got hs=%b vs=%b run=%b expected hs=0 vs=0 run=0",
               vs.hsync, vs.vsync, vs.running);
    else passed++;
  endtask

  // Expects locked already high; the first edge after rst release is edge k.
  task automatic test_startup();
    rst = 1'b0;
    for (int i = 0; i <= 17; i++) begin
      step();
      checks++;
      if (vb.running !== (i == 17))
        $display("FAIL startup_running_big edge k+%0d: got %b expected %b", i, vb.running, (i == 17));
      else passed++;
      checks++;
      if (vs.running !== (i >= 4) || vs.sx !== 5'((i >= 4) ? i - 4 : 0))
        $display("FAIL startup_small edge k+%0d: got run=%b sx=%0d expected run=%b sx=%0d",
                 i, vs.running, vs.sx, (i >= 4), (i >= 4) ? i - 4 : 0);
      else passed++;
    end
    checks++;
    if ({vb.sx, vb.sy, vb.frame_start, vb.line_start, vb.de, vb.hsync, vb.vsync, vb.frame_count}
        !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0})
      $display("FAIL startup_first_cycle: got sx=%0d sy=%0d fs=%b ls=%b de=%b hs=%b vs=%b fc=%0d expected 0 0 1 1 1 1 1 0",
               vb.sx, vb.sy, vb.frame_start, vb.line_start, vb.de, vb.hsync, vb.vsync, vb.frame_count);
    else passed++;
  endtask

  // Starts on the sample showing big sx=0, sy=0.
  task automatic test_line();
    int hs_low = 0, hs_first = -1, hs_last = -1, de_cnt = 0, ls_cnt = 0, bad = 0;
    for (int c = 0; c < 800; c++) begin
      if (c > 0) step();
      if (vb.sx !== 10'(c) || vb.sy !== 10'd0) bad++;
      if (vb.hsync !== ((c >= 656 && c <= 751) ? 1'b0 : 1'b1)) bad++;
      if (vb.de !== (c < 640)) bad++;
      if (vb.hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = c;
        hs_last = c;
      end
      if (vb.de === 1'b1) de_cnt++;
      if (vb.line_start === 1'b1) ls_cnt++;
    end
    checks++;
    if (bad != 0) $display("FAIL line_alignment: got %0d mismatched samples expected 0", bad);
    else passed++;
    checks++;
    if (hs_low != 96 || hs_first != 656 || hs_last != 751)
      $display("FAIL hsync_window: got len=%0d from %0d to %0d expected len=96 from 656 to 751",
               hs_low, hs_first, hs_last);
    else passed++;
    checks++;
    if (de_cnt != 640) $display("FAIL de_per_line: got %0d expected 640", de_cnt);
    else passed++;
    checks++;
    if (ls_cnt != 1) $display("FAIL line_start_count: got %0d expected 1", ls_cnt);
    else passed++;
    step();
    checks++;
    if (vb.sx !== 10'd0 || vb.sy !== 10'd1 || vb.line_start !== 1'b1 || vb.frame_start !== 1'b0)
      $display("FAIL line_wrap: got sx=%0d sy=%0d ls=%b fs=%b expected sx=0 sy=1 ls=1 fs=0",
               vb.sx, vb.sy, vb.line_start, vb.frame_start);
    else passed++;
  endtask

  task automatic test_small_frame();
    int n = 0, bad = 0, vs_cnt = 0, vs_first = -1, de_cnt = 0, hs_cnt = 0, ls_cnt = 0, fs_cnt = 0;
    logic [15:0] fc0, fc_exp;
    while (vs.frame_start !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (vs.frame_start !== 1'b1) $display("FAIL small_frame_start_timeout: got none in %0d cycles expected a pulse", n);
    else passed++;
    fc0 = vs.frame_count;
    for (int c = 0; c < 128; c++) begin
      if (c > 0) step();
      if (vs.sx !== 5'(c % 16) || vs.sy !== 5'(c / 16)) bad++;
      if (vs.vsync !== ((c / 16 == 5) || (c / 16 == 6))) bad++;
      if (vs.hsync !== ((c % 16 >= 10) && (c % 16 <= 12))) bad++;
      if (vs.vsync === 1'b1) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(vs.sy);
      end
      if (vs.de === 1'b1) de_cnt++;
      if (vs.hsync === 1'b1) hs_cnt++;
      if (vs.line_start === 1'b1) ls_cnt++;
      if (vs.frame_start === 1'b1) fs_cnt++;
    end
    checks++;
    if (bad != 0) $display("FAIL small_frame_alignment: got %0d mismatched samples expected 0", bad);
    else passed++;
    checks++;
    if (vs_cnt != 32 || vs_first != 5)
      $display("FAIL small_vsync: got %0d cycles from sy=%0d expected 32 from sy=5", vs_cnt, vs_first);
    else passed++;
    checks++;
    if (de_cnt != 32 || hs_cnt != 24 || ls_cnt != 8 || fs_cnt != 1)
      $display("FAIL small_frame_counts: got de=%0d hs=%0d ls=%0d fs=%0d expected 32 24 8 1",
               de_cnt, hs_cnt, ls_cnt, fs_cnt);
    else passed++;
    step();
    fc_exp = fc0 + 16'd1;
    checks++;
    if (vs.frame_start !== 1'b1 || vs.sx !== 5'd0 || vs.sy !== 5'd0 || vs.frame_count !== fc_exp)
      $display("FAIL small_frame_wrap: got fs=%b sx=%0d sy=%0d fc=%0d expected fs=1 sx=0 sy=0 fc=%0d",
               vs.frame_start, vs.sx, vs.sy, vs.frame_count, fc_exp);
    else passed++;
  endtask

  task automatic test_lock_loss();
    int n = 0;
    while (vb.sx !== 10'd300 && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (vb.sx !== 10'd300) $display("FAIL lock_loss_seek_timeout: got sx=%0d expected 300", vb.sx);
    else passed++;
    locked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({vb.sx, vb.sy, vb.hsync, vb.vsync, vb.de, vb.line_start, vb.frame_start, vb.frame_count, vb.running}
          !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0})
        $display("FAIL lock_loss_idle_big cycle %0d: got sx=%0d sy=%0d de=%b run=%b expected idle",
                 i, vb.sx, vb.sy, vb.de, vb.running);
      else passed++;
    end
    checks++;
    if ({vs.hsync, vs.vsync, vs.running, vs.frame_count} !== {1'b0, 1'b0, 1'b0, 16'd0})
      $display("FAIL lock_loss_idle_small: got hs=%b vs=%b run=%b fc=%0d expected 0 0 0 0",
               vs.hsync, vs.vsync, vs.running, vs.frame_count);
    else passed++;
    locked = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      step();
      checks++;
      if (vb.running !== (i == 17))
        $display("FAIL relock_running edge k+%0d: got %b expected %b", i, vb.running, (i == 17));
      else passed++;
    end
    checks++;
    if (vb.sx !== 10'd0 || vb.sy !== 10'd0 || vb.frame_count !== 16'd0 || vb.frame_start !== 1'b1)
      $display("FAIL relock_restart: got sx=%0d sy=%0d fc=%0d fs=%b expected 0 0 0 1",
               vb.sx, vb.sy, vb.frame_count, vb.frame_start);
    else passed++;
  endtask

  task automatic test_settle_glitch();
    locked = 1'b0;
    repeat (3) step();
    locked = 1'b1;
    repeat (11) step();
    locked = 1'b0;
    step();
    checks++;
    if (vb.running !== 1'b0) $display("FAIL glitch_not_running: got %b expected 0", vb.running);
    else passed++;
    locked = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      step();
      checks++;
      if (vb.running !== (i == 17))
        $display("FAIL glitch_resettle edge j+%0d: got %b expected %b", i, vb.running, (i == 17));
      else passed++;
    end
    checks++;
    if (vb.sx !== 10'd0 || vb.sy !== 10'd0)
      $display("FAIL glitch_restart_pos: got sx=%0d sy=%0d expected 0 0", vb.sx, vb.sy);
    else passed++;
  endtask

  task automatic test_rst_mid_run();
    repeat (10) step();
    checks++;
    if (vb.running !== 1'b1 || vb.sx !== 10'd10)
      $display("FAIL pre_rst_run: got run=%b sx=%0d expected 1 10", vb.running, vb.sx);
    else passed++;
    rst = 1'b1;
    step();
    checks++;
    if ({vb.sx, vb.sy, vb.hsync, vb.vsync, vb.de, vb.line_start, vb.frame_start, vb.frame_count, vb.running}
        !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0})
      $display("FAIL rst_mid_run_idle: got sx=%0d de=%b run=%b expected idle", vb.sx, vb.de, vb.running);
    else passed++;
    checks++;
    if (vs.running !== 1'b0 || vs.hsync !== 1'b0 || vs.vsync !== 1'b0)
      $display("FAIL rst_mid_run_small: got run=%b hs=%b vs=%b expected 0 0 0", vs.running, vs.hsync, vs.vsync);
    else passed++;
    step();
    rst = 1'b0;
    for (int i = 0; i <= 17; i++) begin
      step();
      checks++;
      if (vb.running !== (i == 17))
        $display("FAIL post_rst_running edge k+%0d: got %b expected %b", i, vb.running, (i == 17));
      else passed++;
    end
  endtask

  initial begin
    @(negedge clk_25m);
    test_reset();
    test_startup();
    test_line();
    test_small_frame();
    test_lock_loss();
    test_settle_glitch();
    test_rst_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation exceeded 20000 cycles");
    $fatal(1);
  end

endmodule
